// File: rtl/n64adv_vout_stage_pkg.sv
// Shared types and constants for the PPU video output stage.
package n64adv_vout_stage_pkg;

  localparam int unsigned COLOR_W_DEF      = 8;
  localparam int unsigned SYNC_DLY_MAX_DEF = 7;
  localparam int unsigned FILTER_HOLD_DEF  = 3;
  localparam int unsigned SYNC_W           = 4;
  localparam int unsigned HOLD_CNT_W       = 4;

  // Sync nibble as it sits on top of the pixel word, MSB first.
  typedef struct packed {
    logic n_vsync;
    logic n_blank;
    logic n_hsync;
    logic n_csync;
  } sync_t;

  typedef enum logic [1:0] {
    ORDER_RGB = 2'b00,
    ORDER_BGR = 2'b01,
    ORDER_GRB = 2'b10,
    ORDER_RSV = 2'b11
  } ch_order_e;

  localparam logic [2:0] FILTER_AUTO = 3'b000;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } filt_state_e;

  // Filter code requested by the current configuration.
  function automatic logic [1:0] filter_target(input logic [2:0] cfg_filter,
                                               input logic [1:0] linemult);
    if (cfg_filter == FILTER_AUTO) return linemult;
    else if (cfg_filter[2])        return 2'b11;
    else                           return cfg_filter[1:0] - 2'b01;
  endfunction

endpackage

// File: rtl/n64adv_vout_stage_if.sv
// Pixel, configuration and DAC-side signals of the video output stage.
interface n64adv_vout_stage_if
  import n64adv_vout_stage_pkg::*;
#(
  parameter int unsigned color_width_o = COLOR_W_DEF,
  parameter int unsigned SYNC_DLY_MAX  = SYNC_DLY_MAX_DEF
) ();

  localparam int unsigned DLY_W = $clog2(SYNC_DLY_MAX + 1);

  logic                           vdata_valid_i;
  logic [3*color_width_o+3:0]     vdata_i;
  logic [1:0]                     cfg_ch_order;
  logic [DLY_W-1:0]               cfg_sync_dly;
  logic                           cfg_blank_en;
  logic                           cfg_nEN_YPbPr;
  logic                           cfg_nEN_RGsB;
  logic [2:0]                     cfg_filter;
  logic [1:0]                     cfg_linemult;
  logic                           UseVGA_HVSync;
  logic [3*color_width_o-1:0]     VD_o;
  logic [1:0]                     nCSYNC;
  logic                           nVSYNC_or_F2;
  logic                           nHSYNC_or_F1;
  logic [1:0]                     Filter_o;
  logic                           filter_pending_o;

  modport slave (
    input  vdata_valid_i, vdata_i, cfg_ch_order, cfg_sync_dly, cfg_blank_en,
           cfg_nEN_YPbPr, cfg_nEN_RGsB, cfg_filter, cfg_linemult, UseVGA_HVSync,
    output VD_o, nCSYNC, nVSYNC_or_F2, nHSYNC_or_F1, Filter_o, filter_pending_o
  );

  modport master (
    output vdata_valid_i, vdata_i, cfg_ch_order, cfg_sync_dly, cfg_blank_en,
           cfg_nEN_YPbPr, cfg_nEN_RGsB, cfg_filter, cfg_linemult, UseVGA_HVSync,
    input  VD_o, nCSYNC, nVSYNC_or_F2, nHSYNC_or_F1, Filter_o, filter_pending_o
  );

endinterface

// File: rtl/n64adv_vout_stage_filter_debounce.sv
// Applies a new analogue filter code only after it has persisted over several frames.
module n64adv_vout_stage_filter_debounce
  import n64adv_vout_stage_pkg::*;
#(
  parameter int unsigned FILTER_HOLD = FILTER_HOLD_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_i,
  input  logic       n_vsync_i,
  input  logic [1:0] target_i,
  output logic [1:0] filter_o,
  output logic [1:0] filter_nxt_c,
  output logic       pending_o
);

  filt_state_e           state_q, state_d;
  logic [1:0]            cand_q, cand_d;
  logic [1:0]            filter_q, filter_d;
  logic [HOLD_CNT_W-1:0] cnt_q, cnt_d;
  logic                  prev_vs_q, prev_vs_d;
  logic                  pending_q, pending_d;
  logic                  vs_fall_c;

  // State and datapath registers; vsync history starts inactive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_STABLE;
      cand_q    <= 2'b00;
      filter_q  <= 2'b00;
      cnt_q     <= '0;
      prev_vs_q <= 1'b1;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      filter_q  <= filter_d;
      cnt_q     <= cnt_d;
      prev_vs_q <= prev_vs_d;
      pending_q <= pending_d;
    end
  end

  // Next state: leave STABLE on any mismatch, resolve PENDING only at frame starts.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    filter_d  = filter_q;
    cnt_d     = cnt_q;
    prev_vs_d = valid_i ? n_vsync_i : prev_vs_q;
    vs_fall_c = valid_i & prev_vs_q & ~n_vsync_i;
    case (state_q)
      ST_STABLE: begin
        if (target_i != filter_q) begin
          state_d = ST_PENDING;
          cand_d  = target_i;
          cnt_d   = '0;
        end
      end
      ST_PENDING: begin
        if (vs_fall_c) begin
          if (target_i == filter_q) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (target_i == cand_q) begin
            if (cnt_q + HOLD_CNT_W'(1) == HOLD_CNT_W'(FILTER_HOLD)) begin
              filter_d = cand_q;
              state_d  = ST_STABLE;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + HOLD_CNT_W'(1);
            end
          end else begin
            cand_d = target_i;
            cnt_d  = '0;
          end
        end
      end
      default: state_d = ST_STABLE;
    endcase
    pending_d = (state_d == ST_PENDING);
  end

  assign filter_o     = filter_q;
  assign filter_nxt_c = filter_d;
  assign pending_o    = pending_q;

endmodule

// File: rtl/n64adv_vout_stage.sv
// Final PPU output stage: channel order, blanking, sync delay, csync gating and pin mux.
module n64adv_vout_stage
  import n64adv_vout_stage_pkg::*;
#(
  parameter int unsigned color_width_o = COLOR_W_DEF,
  parameter int unsigned SYNC_DLY_MAX  = SYNC_DLY_MAX_DEF,
  parameter int unsigned FILTER_HOLD   = FILTER_HOLD_DEF
) (
  input logic                VCLK,
  input logic                nRST,
  n64adv_vout_stage_if.slave vif
);

  localparam int unsigned CW    = color_width_o;
  localparam int unsigned VW    = 3 * CW;
  localparam int unsigned DLY_W = $clog2(SYNC_DLY_MAX + 1);

  sync_t            sync_in_c, sel_c;
  logic [CW-1:0]    r_c, g_c, b_c;
  logic [VW-1:0]    ordered_c;
  logic [DLY_W-1:0] dly_sel_c;
  logic [1:0]       filter_q, filter_nxt_c;
  logic             pending_q;

  sync_t         dly_q [SYNC_DLY_MAX];
  sync_t         dly_d [SYNC_DLY_MAX];
  logic [VW-1:0] vd_q, vd_d;
  logic [1:0]    cs_q, cs_d;
  logic          vs_pin_q, vs_pin_d;
  logic          hs_pin_q, hs_pin_d;

  assign sync_in_c = sync_t'(vif.vdata_i[VW +: SYNC_W]);
  assign r_c       = vif.vdata_i[2*CW +: CW];
  assign g_c       = vif.vdata_i[CW +: CW];
  assign b_c       = vif.vdata_i[0 +: CW];

  // Saturate the requested delay and pick the matching tap.
  always_comb begin
    if (32'(vif.cfg_sync_dly) > SYNC_DLY_MAX) dly_sel_c = DLY_W'(SYNC_DLY_MAX);
    else                                      dly_sel_c = vif.cfg_sync_dly;
    sel_c = sync_in_c;
    for (int unsigned i = 0; i < SYNC_DLY_MAX; i++) begin
      if (dly_sel_c == DLY_W'(i + 1)) sel_c = dly_q[i];
    end
  end

  // Runtime channel permutation; the reserved code falls back to RGB.
  always_comb begin
    case (ch_order_e'(vif.cfg_ch_order))
      ORDER_BGR: ordered_c = {b_c, g_c, r_c};
      ORDER_GRB: ordered_c = {g_c, r_c, b_c};
      default:   ordered_c = {r_c, g_c, b_c};
    endcase
  end

  n64adv_vout_stage_filter_debounce #(
    .FILTER_HOLD (FILTER_HOLD)
  ) u_filter_debounce (
    .clk          (VCLK),
    .rst_n        (nRST),
    .valid_i      (vif.vdata_valid_i),
    .n_vsync_i    (sync_in_c.n_vsync),
    .target_i     (filter_target(vif.cfg_filter, vif.cfg_linemult)),
    .filter_o     (filter_q),
    .filter_nxt_c (filter_nxt_c),
    .pending_o    (pending_q)
  );

  // Output and delay-line registers; delayed syncs start inactive.
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < SYNC_DLY_MAX; i++) dly_q[i] <= '1;
      vd_q     <= '0;
      cs_q     <= 2'b00;
      vs_pin_q <= 1'b0;
      hs_pin_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < SYNC_DLY_MAX; i++) dly_q[i] <= dly_d[i];
      vd_q     <= vd_d;
      cs_q     <= cs_d;
      vs_pin_q <= vs_pin_d;
      hs_pin_q <= hs_pin_d;
    end
  end

  // Capture on valid pixels; pins follow the filter code every cycle in filter mode.
  always_comb begin
    dly_d    = dly_q;
    vd_d     = vd_q;
    cs_d     = cs_q;
    vs_pin_d = vs_pin_q;
    hs_pin_d = hs_pin_q;
    if (vif.vdata_valid_i) begin
      dly_d[0] = sync_in_c;
      for (int unsigned i = 1; i < SYNC_DLY_MAX; i++) dly_d[i] = dly_q[i-1];
      vd_d = (vif.cfg_blank_en && !sel_c.n_blank) ? '0 : ordered_c;
      cs_d = {sel_c.n_csync,
              sel_c.n_csync & (~vif.cfg_nEN_YPbPr | ~vif.cfg_nEN_RGsB)};
    end
    if (vif.UseVGA_HVSync) begin
      if (vif.vdata_valid_i) begin
        vs_pin_d = sel_c.n_vsync;
        hs_pin_d = sel_c.n_hsync;
      end
    end else begin
      vs_pin_d = filter_nxt_c[1];
      hs_pin_d = filter_nxt_c[0];
    end
  end

  assign vif.VD_o             = vd_q;
  assign vif.nCSYNC           = cs_q;
  assign vif.nVSYNC_or_F2     = vs_pin_q;
  assign vif.nHSYNC_or_F1     = hs_pin_q;
  assign vif.Filter_o         = filter_q;
  assign vif.filter_pending_o = pending_q;

endmodule

// File: tb/tb_n64adv_vout_stage.sv
// Directed plus randomized bench for the video output stage against a queue-based model.
module tb_n64adv_vout_stage;

  localparam int unsigned CW   = 8;
  localparam int unsigned DMAX = 7;
  localparam int unsigned HOLD = 3;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  n64adv_vout_stage_if #(.color_width_o(CW), .SYNC_DLY_MAX(DMAX)) vif ();

  n64adv_vout_stage #(
    .color_width_o (CW),
    .SYNC_DLY_MAX  (DMAX),
    .FILTER_HOLD   (HOLD)
  ) dut (
    .VCLK (clk),
    .nRST (nrst),
    .vif  (vif)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: history of syncs seen on valid pixels, newest first.
  logic [3:0]  hist[$];
  logic [23:0] m_vd;
  logic [1:0]  m_cs;
  logic        m_v, m_h;
  logic [1:0]  m_f;
  logic        m_pend;
  logic [1:0]  m_cand;
  int          m_cnt;
  logic        m_prev_vs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] want_filter(input logic [2:0] f, input logic [1:0] lm);
    int code;
    code = int'(f);
    if (code == 0) return lm;
    if (code > 4) code = 4;
    return 2'(code - 1);
  endfunction

  task automatic model_reset();
    hist.delete();
    m_vd = '0; m_cs = 2'b00; m_v = 1'b0; m_h = 1'b0;
    m_f = 2'b00; m_pend = 1'b0; m_cand = 2'b00; m_cnt = 0; m_prev_vs = 1'b1;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    logic [3:0]  s_in, sel;
    logic [7:0]  r, g, b;
    logic [1:0]  tgt;
    logic        valid, fall;
    int          d;
    valid = vif.vdata_valid_i;
    s_in  = vif.vdata_i[27:24];
    r = vif.vdata_i[23:16]; g = vif.vdata_i[15:8]; b = vif.vdata_i[7:0];
    d = int'(vif.cfg_sync_dly);
    if (d > int'(DMAX)) d = int'(DMAX);
    if (d == 0) sel = s_in;
    else if (hist.size() >= d) sel = hist[d-1];
    else sel = 4'hF;
    tgt  = want_filter(vif.cfg_filter, vif.cfg_linemult);
    fall = valid && m_prev_vs && !s_in[3];
    if (valid) m_prev_vs = s_in[3];
    if (!m_pend) begin
      if (tgt != m_f) begin m_pend = 1'b1; m_cand = tgt; m_cnt = 0; end
    end else if (fall) begin
      if (tgt == m_f) m_pend = 1'b0;
      else if (tgt == m_cand) begin
        m_cnt++;
        if (m_cnt == int'(HOLD)) begin m_f = m_cand; m_pend = 1'b0; end
      end else begin m_cand = tgt; m_cnt = 0; end
    end
    if (valid) begin
      case (vif.cfg_ch_order)
        2'b01:   m_vd = {b, g, r};
        2'b10:   m_vd = {g, r, b};
        default: m_vd = {r, g, b};
      endcase
      if (vif.cfg_blank_en && !sel[2]) m_vd = '0;
      m_cs = {sel[0], (!vif.cfg_nEN_YPbPr || !vif.cfg_nEN_RGsB) ? sel[0] : 1'b0};
      hist.push_front(s_in);
      if (hist.size() > DMAX) void'(hist.pop_back());
    end
    if (vif.UseVGA_HVSync) begin
      if (valid) begin m_v = sel[3]; m_h = sel[1]; end
    end else begin
      m_v = m_f[1]; m_h = m_f[0];
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("vd",      32'(vif.VD_o),             32'(m_vd));
    check("csync",   32'(vif.nCSYNC),           32'(m_cs));
    check("vs_pin",  32'(vif.nVSYNC_or_F2),     32'(m_v));
    check("hs_pin",  32'(vif.nHSYNC_or_F1),     32'(m_h));
    check("filter",  32'(vif.Filter_o),         32'(m_f));
    check("pending", 32'(vif.filter_pending_o), 32'(m_pend));
  endtask

  task automatic pix(input logic v, input logic [3:0] s, input logic [23:0] rgb);
    vif.vdata_valid_i = v;
    vif.vdata_i       = {s, rgb};
    cyc();
  endtask

  task automatic vs_edge();
    pix(1'b1, 4'hF, 24'h010203);
    pix(1'b1, 4'h7, 24'h040506);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    #3;
    model_reset();
    check("rst_vd",      32'(vif.VD_o),             32'h0);
    check("rst_csync",   32'(vif.nCSYNC),           32'h0);
    check("rst_vs_pin",  32'(vif.nVSYNC_or_F2),     32'h0);
    check("rst_hs_pin",  32'(vif.nHSYNC_or_F1),     32'h0);
    check("rst_filter",  32'(vif.Filter_o),         32'h0);
    check("rst_pending", 32'(vif.filter_pending_o), 32'h0);
    nrst = 1'b1;
  endtask

  initial begin
    vif.vdata_valid_i = 1'b0;
    vif.vdata_i       = {4'hF, 24'h0};
    vif.cfg_ch_order  = 2'b00;
    vif.cfg_sync_dly  = '0;
    vif.cfg_blank_en  = 1'b0;
    vif.cfg_nEN_YPbPr = 1'b1;
    vif.cfg_nEN_RGsB  = 1'b1;
    vif.cfg_filter    = 3'b000;
    vif.cfg_linemult  = 2'b00;
    vif.UseVGA_HVSync = 1'b1;
    #12;
    do_reset();
    pix(1'b0, 4'hF, 24'h0);

    // Channel order BGR, csync gated off with both encoders disabled.
    vif.cfg_ch_order = 2'b01;
    pix(1'b1, 4'hF, 24'h123456);
    check("order_bgr", 32'(vif.VD_o),   32'h563412);
    check("cs_gated",  32'(vif.nCSYNC), 32'h2);

    // Sync delay of 3 valid pixels, valid every second cycle.
    vif.cfg_ch_order = 2'b00;
    vif.cfg_sync_dly = 3'd3;
    for (int k = 0; k < 8; k++) begin
      logic [23:0] rgb;
      rgb = 24'(32'h101010 * (k + 1));
      pix(1'b1, (k == 0) ? 4'hD : 4'hF, rgb);
      check($sformatf("dly_hs_%0d", k), 32'(vif.nHSYNC_or_F1), (k == 3) ? 32'h0 : 32'h1);
      check($sformatf("dly_vd_%0d", k), 32'(vif.VD_o), 32'(rgb));
      pix(1'b0, 4'hF, 24'h0);
    end

    // Blanking.
    vif.cfg_sync_dly = '0;
    vif.cfg_blank_en = 1'b1;
    pix(1'b1, 4'hB, 24'hFFFFFF);
    check("blank_on", 32'(vif.VD_o), 32'h0);
    vif.cfg_blank_en = 1'b0;
    pix(1'b1, 4'hB, 24'hFFFFFF);
    check("blank_off", 32'(vif.VD_o), 32'hFFFFFF);

    // Sync-on-green passes csync to the gated output.
    vif.cfg_nEN_RGsB = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pix(1'b1, (k % 2 == 1) ? 4'hE : 4'hF, 24'h0);
      check($sformatf("sog_cs_%0d", k), 32'(vif.nCSYNC), (k % 2 == 1) ? 32'h0 : 32'h3);
    end
    vif.cfg_nEN_RGsB = 1'b1;
    pix(1'b1, 4'hF, 24'h0);
    check("sog_off", 32'(vif.nCSYNC), 32'h2);

    // Auto filter follows the line multiplier after three frame starts.
    do_reset();
    vif.UseVGA_HVSync = 1'b0;
    vif.cfg_linemult  = 2'b01;
    pix(1'b0, 4'hF, 24'h0);
    check("pend_now", 32'(vif.filter_pending_o), 32'h1);
    for (int e = 1; e <= 3; e++) begin
      vs_edge();
      check($sformatf("hold_filter_%0d", e), 32'(vif.Filter_o), (e == 3) ? 32'h1 : 32'h0);
    end
    check("hold_pend_done", 32'(vif.filter_pending_o), 32'h0);
    check("hold_f1_pin",    32'(vif.nHSYNC_or_F1),     32'h1);

    // Transient multiplier change is ignored.
    do_reset();
    vif.cfg_linemult = 2'b00;
    pix(1'b0, 4'hF, 24'h0);
    vif.cfg_linemult = 2'b01;
    pix(1'b0, 4'hF, 24'h0);
    vs_edge();
    vif.cfg_linemult = 2'b00;
    vs_edge();
    check("abort_pend",   32'(vif.filter_pending_o), 32'h0);
    check("abort_filter", 32'(vif.Filter_o),         32'h0);

    // Out-of-range fixed filter code clamps to the widest filter.
    vif.cfg_filter = 3'b111;
    pix(1'b0, 4'hF, 24'h0);
    for (int e = 0; e < 3; e++) vs_edge();
    check("clamp_filter", 32'(vif.Filter_o), 32'h3);
    check("clamp_pins",   32'({vif.nVSYNC_or_F2, vif.nHSYNC_or_F1}), 32'h3);

    // Randomized traffic.
    vif.cfg_filter = 3'b000;
    for (int n = 0; n < 800; n++) begin
      vif.cfg_ch_order  = 2'($urandom_range(0, 3));
      vif.cfg_sync_dly  = 3'($urandom_range(0, 7));
      vif.cfg_blank_en  = 1'($urandom_range(0, 1));
      vif.cfg_nEN_YPbPr = 1'($urandom_range(0, 1));
      vif.cfg_nEN_RGsB  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) vif.cfg_filter   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) vif.cfg_linemult = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) vif.UseVGA_HVSync = ~vif.UseVGA_HVSync;
      pix(($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)), 24'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
